// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: circular FIFO of {pc, instr}
// with almost-full back-pressure, branch flush and a sticky overflow flag.
module instr_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        stall_full_instr,
    output logic        overflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(DEPTH - AF_MARGIN);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic full;
    logic push;
    logic pop;

    assign full = (count == CNT_FULL);
    // A full buffer refuses the push even when a pop frees a slot in the same cycle.
    assign push = in_valid & ~flush & ~full;
    assign pop  = out_valid & out_ready & ~flush;

    assign out_valid        = (count != '0);
    assign out_pc           = mem[rd_ptr][63:32];
    assign out_instr        = mem[rd_ptr][31:0];
    assign stall_full_instr = (count >= CNT_AF);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_err <= 1'b0;
        end else if (in_valid && !flush && full && !pop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: stimulus queues expected entries, a
// negedge monitor compares every accepted pop against the queue head.
module tb_instr_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        stall_full_instr;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    entry_t sb_q[$];

    instr_buffer #(.DEPTH(8), .AF_MARGIN(2)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_pc            (in_pc),
        .in_instr         (in_instr),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .stall_full_instr (stall_full_instr),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a push for the next edge; expect_accept decides whether it is scored.
    task automatic drive_push(input logic [31:0] pc, input logic [31:0] instr, input bit expect_accept);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        if (expect_accept) sb_q.push_back('{pc: pc, instr: instr});
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready && !flush) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", out_pc);
            end else begin
                entry_t e;
                e = sb_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    errors++;
                    $display("FAIL pop_order: got %08h/%08h expected %08h/%08h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_stall", 32'(stall_full_instr), 32'd0);
        check("reset_overflow", 32'(overflow_err), 32'd0);

        // Single instruction; push is already presented when reset releases.
        @(posedge clk); #1;
        drive_push(32'h1C00_0000, 32'h0280_0C0C, 1'b1);
        rstn = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_pc", out_pc, 32'h1C00_0000);
        check("single_instr", out_instr, 32'h0280_0C0C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drained", 32'(out_valid), 32'd0);

        // Fill to almost-full and full.
        for (int i = 0; i < 8; i++) begin
            drive_push(32'h1C00_0000 + 32'(4 * i), instr_of(32'h1C00_0000 + 32'(4 * i)), 1'b1);
            tick();
            if (i == 4) check("af_below_at5", 32'(stall_full_instr), 32'd0);
            if (i == 5) check("af_rise_at6", 32'(stall_full_instr), 32'd1);
        end
        // Full with simultaneous pop: push refused, no overflow.
        drive_push(32'h1C00_0F00, instr_of(32'h1C00_0F00), 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pushpop_overflow", 32'(overflow_err), 32'd0);
        check("full_pushpop_head", out_pc, 32'h1C00_0004);
        // Back to 8, then a refused push sets overflow.
        drive_push(32'h1C00_0020, instr_of(32'h1C00_0020), 1'b1);
        tick();
        drive_push(32'h1C00_0024, instr_of(32'h1C00_0024), 1'b0);
        tick();
        in_valid = 1'b0;
        check("overflow_set", 32'(overflow_err), 32'd1);
        check("overflow_head", out_pc, 32'h1C00_0004);
        check("overflow_stall", 32'(stall_full_instr), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) check("drain_7_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b0;
        check("drain_8_empty", 32'(out_valid), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        check("overflow_sticky", 32'(overflow_err), 32'd1);

        // Wrap-around streaming with continuous pop.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_push(32'h1C00_0000 + 32'(4 * i), instr_of(32'h1C00_0000 + 32'(4 * i)), 1'b1);
            tick();
            if (stall_full_instr !== 1'b0 || out_valid !== 1'b1)
                check("stream_count_le1", {30'd0, stall_full_instr, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_empty", 32'(out_valid), 32'd0);
        check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // Flush priority over same-cycle push and pop.
        for (int i = 0; i < 5; i++) begin
            drive_push(32'h1C00_0100 + 32'(4 * i), instr_of(32'h1C00_0100 + 32'(4 * i)), 1'b1);
            tick();
        end
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        drive_push(32'h1C00_0200, instr_of(32'h1C00_0200), 1'b0);
        sb_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_stall", 32'(stall_full_instr), 32'd0);
        check("flush_keeps_overflow", 32'(overflow_err), 32'd1);
        drive_push(32'h1C00_1000, instr_of(32'h1C00_1000), 1'b1);
        tick();
        in_valid = 1'b0;
        check("flush_next_pc", out_pc, 32'h1C00_1000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("flush_next_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges with count=4.
        for (int i = 0; i < 4; i++) begin
            drive_push(32'h1C00_0300 + 32'(4 * i), instr_of(32'h1C00_0300 + 32'(4 * i)), 1'b1);
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("areset_pre_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        sb_q.delete();
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_stall", 32'(stall_full_instr), 32'd0);
        check("areset_overflow", 32'(overflow_err), 32'd0);
        tick();
        rstn = 1'b1;
        drive_push(32'h1C00_2000, instr_of(32'h1C00_2000), 1'b1);
        tick();
        in_valid = 1'b0;
        check("post_reset_pc", out_pc, 32'h1C00_2000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_reset_empty", 32'(out_valid), 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
